pc_unit: RTL and testbench

//  Program counter stage; owns the architectural PC and drives the `pc` input of
//  the ALU operand-1 select stage and the instruction fetch address.
//  - Steps the PC sequentially.
//  - Accepts resolved jump/branch targets from the ALU result.
//  - Drains the pipeline: holds a FLUSH_CYCLES-cycle bubble after every taken

---
 rtl/pc_unit_if.sv | 23 ++
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the PC stage and its neighbours: control inputs
// from the ALU and downstream, and the registered PC outputs.
interface pc_unit_if #(
  parameter int unsigned REG_LEN = 32
);
  logic               stall;
  logic               jump_en;
  logic [REG_LEN-1:0] jump_addr;
  logic [REG_LEN-1:0] pc;
  logic               pc_valid;
  logic               flush;
  logic               jump_misalign;

  modport master (
    output stall, jump_en, jump_addr,
    input  pc, pc_valid, flush, jump_misalign
  );

  modport slave (
    input  stall, jump_en, jump_addr,
    output pc, pc_valid, flush, jump_misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter stage: sequential stepping, jump redirect, and a fixed
// bubble after each taken jump so the delayed-PC consumer drains cleanly.
module pc_unit #(
  parameter int unsigned        REG_LEN      = 32,
  parameter logic [REG_LEN-1:0] RESET_ADDR   = '0,
  parameter int unsigned        PC_STEP      = 4,
  parameter int unsigned        FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic               flush_q, flush_d;
  logic               pc_valid_q, pc_valid_d;
  logic               misalign_q, misalign_d;

  // State register and all output/datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pc_q       <= RESET_ADDR;
      flush_q    <= 1'b0;
      pc_valid_q <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state: jumps only taken from RUN; FLUSH exits once the counter is spent
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.jump_en) state_d = FLUSH;
      FLUSH:   if (cnt_q == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs and datapath; jump_en and stall are ignored while draining
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    pc_valid_d = pc_valid_q;
    misalign_d = 1'b0;
    case (state_q)
      RUN: begin
        flush_d    = 1'b0;
        pc_valid_d = 1'b1;
        if (bus.jump_en) begin
          pc_d       = {bus.jump_addr[REG_LEN-1:2], 2'b00};
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          flush_d    = 1'b1;
          pc_valid_d = 1'b0;
          misalign_d = |bus.jump_addr[1:0];
        end else if (!bus.stall) begin
          pc_d = pc_q + REG_LEN'(PC_STEP);
        end
      end
      FLUSH: begin
        if (cnt_q != '0) begin
          cnt_d      = cnt_q - CNT_W'(1);
          flush_d    = 1'b1;
          pc_valid_d = 1'b0;
        end else begin
          flush_d    = 1'b0;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        flush_d    = 1'b0;
        pc_valid_d = 1'b1;
      end
    endcase
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.flush         = flush_q;
  assign bus.jump_misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic,
// compared against a cycle-level reference model of the PC stage.
module tb_pc_unit;

  localparam int unsigned REG_LEN      = 32;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_ADDR   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: PC, bubble cycles still to show, misalign pulse
  logic [31:0] m_pc;
  int          m_left;
  logic        m_mis;

  pc_unit_if #(.REG_LEN(REG_LEN)) ifc ();

  pc_unit #(
    .REG_LEN(REG_LEN),
    .RESET_ADDR(RESET_ADDR),
    .PC_STEP(4),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc   = RESET_ADDR;
    m_left = 0;
    m_mis  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic j, input logic [31:0] a);
    m_mis = 1'b0;
    if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (j) begin
      m_pc   = a & 32'hFFFF_FFFC;
      m_left = FLUSH_CYCLES;
      m_mis  = (a % 4) != 0;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check(input string tag);
    logic exp_flush;
    exp_flush = (m_left != 0);
    n_cmp++;
    assert (ifc.pc === m_pc) else begin
      n_fail++;
      $error("FAIL %s.pc obs=%h exp=%h", tag, ifc.pc, m_pc);
    end
    n_cmp++;
    assert (ifc.flush === exp_flush) else begin
      n_fail++;
      $error("FAIL %s.flush obs=%b exp=%b", tag, ifc.flush, exp_flush);
    end
    n_cmp++;
    assert (ifc.pc_valid === !exp_flush) else begin
      n_fail++;
      $error("FAIL %s.pc_valid obs=%b exp=%b", tag, ifc.pc_valid, !exp_flush);
    end
    n_cmp++;
    assert (ifc.jump_misalign === m_mis) else begin
      n_fail++;
      $error("FAIL %s.misalign obs=%b exp=%b", tag, ifc.jump_misalign, m_mis);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (ifc.pc === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, ifc.pc, exp);
    end
  endtask

  // Called at a negedge: drive inputs, clock once, sample at the next negedge
  task automatic cycle(input logic s, input logic j, input logic [31:0] a, input string tag);
    ifc.stall     = s;
    ifc.jump_en   = j;
    ifc.jump_addr = a;
    @(posedge clk);
    model_step(s, j, a);
    @(negedge clk);
    check(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".async"});
    @(negedge clk);
    rst = 1'b0;
    check({tag, ".release"});
  endtask

  initial begin
    rst           = 1'b1;
    ifc.stall     = 1'b0;
    ifc.jump_en   = 1'b0;
    ifc.jump_addr = '0;
    model_reset();
    @(negedge clk);
    check("reset");
    rst = 1'b0;
    check("reset_release");

    // 1. sequential stepping
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, "seq");
    check_pc("seq_pc8", 32'h8);
    // 2. stall holds PC
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, "stall");
    check_pc("stall_hold", 32'h8);
    cycle(1'b0, 1'b0, 32'h0, "resume");
    check_pc("resume_pc12", 32'hC);
    // 3. taken jump, bubble, resume at target; 4. jump during flush ignored
    cycle(1'b0, 1'b1, 32'h100, "jump");
    check_pc("jump_target", 32'h100);
    cycle(1'b1, 1'b1, 32'h200, "flush_jump_ignored");
    cycle(1'b0, 1'b0, 32'h0, "flush_end");
    check_pc("post_flush", 32'h100);
    cycle(1'b0, 1'b0, 32'h0, "step_after_jump");
    check_pc("step_104", 32'h104);
    // 5. misaligned target
    cycle(1'b0, 1'b1, 32'h102, "misalign");
    check_pc("misalign_pc", 32'h100);
    cycle(1'b0, 1'b0, 32'h0, "misalign_clear");
    cycle(1'b0, 1'b0, 32'h0, "misalign_drain");
    // back-to-back jump in first RUN cycle after flush
    cycle(1'b0, 1'b1, 32'h40, "b2b_jump");
    // 6. reset mid-flush, then wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'h300, "pre_reset_jump");
    async_reset("mid_flush");
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_jump");
    cycle(1'b0, 1'b0, 32'h0, "wrap_flush");
    cycle(1'b0, 1'b0, 32'h0, "wrap_exit");
    check_pc("wrap_top", 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, "wrap_step");
    check_pc("wrap_zero", 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        s, j;
      logic [31:0] a;
      s = ($urandom_range(0, 99) < 30);
      j = ($urandom_range(0, 99) < 12);
      a = $urandom();
      if ($urandom_range(0, 99) < 2) async_reset("rand");
      else cycle(s, j, a, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global timeout guard
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout obs=running exp=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
